// File: rtl/button_conditioner.sv
// Button front end: per-channel 2-FF synchroniser, debounce FSM, press/release
// edge pulses and a one-shot long-press pulse, all outputs registered.
module button_conditioner #(
    parameter int unsigned NUM_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned CNT_W             = 26
) (
    input  logic               CLK_50,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_clean_n,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_press
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    // NOTE: reset asserts asynchronously but releases on a clock edge, so no
    // flop sees reset removal near its own clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [1:0]       sync_q;
        logic             pin_pressed;
        state_e           state_q, state_d;
        logic [CNT_W-1:0] deb_q, deb_d;
        logic [CNT_W-1:0] hold_q, hold_d;
        logic             long_fired_q, long_fired_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             long_q, long_d;
        logic             clean_n_q;

        // Synchroniser runs on the raw reset so it is already tracking the pin
        // while the debounce logic is still held by the synchronised reset.
        always_ff @(posedge CLK_50 or posedge reset) begin
            if (reset) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], btn_n[i]};
            end
        end

        assign pin_pressed = ~sync_q[1];

        // NOTE: every always_comb output gets a default first, so no path can
        // leave a variable unassigned and infer a latch.
        always_comb begin
            state_d      = state_q;
            deb_d        = '0;
            hold_d       = hold_q;
            long_fired_d = long_fired_q;
            press_d      = 1'b0;
            release_d    = 1'b0;
            long_d       = 1'b0;

            if (pin_pressed != (state_q == PRESSED)) begin
                if (deb_q == DEB_LAST) begin
                    if (state_q == RELEASED) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        state_d      = RELEASED;
                        release_d    = 1'b1;
                        long_fired_d = 1'b0;
                    end
                end else begin
                    deb_d = deb_q + CNT_W'(1);
                end
            end

            // Hold timer only advances while the press is staying accepted.
            if (state_q == PRESSED && state_d == PRESSED) begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end else if (!long_fired_q) begin
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end
            end
        end

        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        always_ff @(posedge CLK_50 or posedge rst_int) begin
            if (rst_int) begin
                state_q      <= RELEASED;
                deb_q        <= '0;
                hold_q       <= '0;
                long_fired_q <= 1'b0;
                press_q      <= 1'b0;
                release_q    <= 1'b0;
                long_q       <= 1'b0;
                clean_n_q    <= 1'b1;
            end else begin
                state_q      <= state_d;
                deb_q        <= deb_d;
                hold_q       <= hold_d;
                long_fired_q <= long_fired_d;
                press_q      <= press_d;
                release_q    <= release_d;
                long_q       <= long_d;
                clean_n_q    <= (state_d != PRESSED);
            end
        end

        assign btn_level[i]     = (state_q == PRESSED);
        assign btn_clean_n[i]   = clean_n_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long-press times;
// expected edge numbers are hand-derived from the pin-change edge.
module tb_button_conditioner;

    localparam int NB = 2;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_clean_n;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] release_pulse;
    logic [NB-1:0] long_press;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int press_cnt [NB];
    int press_at  [NB];
    int rel_cnt   [NB];
    int rel_at    [NB];
    int long_cnt  [NB];
    int long_at   [NB];
    int rise_at   [NB];
    int fall_at   [NB];
    logic [NB-1:0] level_prev;
    int overlap_cnt = 0;
    int clean_bad   = 0;
    int start;

    button_conditioner #(
        .NUM_BTN          (NB),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(12),
        .CNT_W            (8)
    ) dut (
        .CLK_50       (clk),
        .reset        (rst),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .btn_clean_n  (btn_clean_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int b = 0; b < NB; b++) begin
            press_cnt[b] = 0; press_at[b] = -1;
            rel_cnt[b]   = 0; rel_at[b]   = -1;
            long_cnt[b]  = 0; long_at[b]  = -1;
            rise_at[b]   = -1; fall_at[b] = -1;
        end
        level_prev = btn_level;
    endtask

    // Each sample is taken on the falling edge, i.e. reflects the posedge cyc.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                if (press_pulse[b])   begin press_cnt[b]++; press_at[b] = cyc; end
                if (release_pulse[b]) begin rel_cnt[b]++;   rel_at[b]   = cyc; end
                if (long_press[b])    begin long_cnt[b]++;  long_at[b]  = cyc; end
                if (btn_level[b] && !level_prev[b]) rise_at[b] = cyc;
                if (!btn_level[b] && level_prev[b]) fall_at[b] = cyc;
                if (press_pulse[b] && release_pulse[b]) overlap_cnt++;
                if (btn_clean_n[b] === btn_level[b]) clean_bad++;
                level_prev[b] = btn_level[b];
            end
        end
    endtask

    initial begin
        logic [9:0] bounce;

        rst   = 1'b1;
        btn_n = 2'b11;
        clear_stats();

        // Reset state
        run_cycles(5);
        check("rst_level",   btn_level,     0);
        check("rst_clean_n", btn_clean_n,   3);
        check("rst_press",   press_pulse,   0);
        check("rst_release", release_pulse, 0);
        check("rst_long",    long_press,    0);
        rst = 1'b0;
        clear_stats();
        run_cycles(20);
        check("idle_press",   press_cnt[0] + press_cnt[1], 0);
        check("idle_release", rel_cnt[0] + rel_cnt[1],     0);
        check("idle_long",    long_cnt[0] + long_cnt[1],   0);

        // Clean press held 40 cycles: pin seen at edge start+1, accepted at
        // start+6, long press 12 edges later.
        clear_stats();
        start = cyc;
        btn_n[0] = 1'b0;
        run_cycles(40);
        check("press_cnt",      press_cnt[0], 1);
        check("press_edge",     press_at[0],  start + 6);
        check("level_rise",     rise_at[0],   start + 6);
        check("clean_n_low",    btn_clean_n[0], 0);
        check("long_cnt",       long_cnt[0],  1);
        check("long_edge",      long_at[0],   start + 18);
        check("ch1_untouched",  press_cnt[1] + long_cnt[1], 0);
        check("ch1_level",      btn_level[1], 0);
        check("no_rel_in_hold", rel_cnt[0],   0);

        // Release after long press
        clear_stats();
        start = cyc;
        btn_n[0] = 1'b1;
        run_cycles(12);
        check("release_cnt",   rel_cnt[0],  1);
        check("release_edge",  rel_at[0],   start + 6);
        check("level_fall",    fall_at[0],  start + 6);
        check("no_long_after", long_cnt[0] + press_cnt[0], 0);

        // Bounce on channel 1: final settle (index 5) sampled at start+6
        clear_stats();
        start  = cyc;
        bounce = 10'b00000_10010; // index 0 is LSB: 0,1,0,0,1,0,0,0,0,0
        for (int j = 0; j < 10; j++) begin
            btn_n[1] = bounce[j];
            run_cycles(1);
        end
        run_cycles(10);
        check("bounce_press_cnt", press_cnt[1], 1);
        check("bounce_press_edge", press_at[1], start + 11);
        check("bounce_no_release", rel_cnt[1],  0);
        check("bounce_ch0_quiet",  press_cnt[0] + rel_cnt[0], 0);
        btn_n[1] = 1'b1;
        clear_stats();
        run_cycles(10);
        check("bounce_release_cnt", rel_cnt[1], 1);

        // Short press: 10 cycles low, released before the long threshold
        clear_stats();
        start = cyc;
        btn_n[0] = 1'b0;
        run_cycles(10);
        btn_n[0] = 1'b1;
        run_cycles(20);
        check("short_press_cnt",    press_cnt[0], 1);
        check("short_press_edge",   press_at[0],  start + 6);
        check("short_release_cnt",  rel_cnt[0],   1);
        check("short_release_edge", rel_at[0],    start + 16);
        check("short_no_long",      long_cnt[0],  0);

        // Reset mid-press with hold counter at 6 (accepted at start+6)
        clear_stats();
        start = cyc;
        btn_n[0] = 1'b0;
        run_cycles(12);
        check("pre_rst_level", btn_level[0], 1);
        rst = 1'b1;
        #1;
        check("midrst_level",   btn_level,     0);
        check("midrst_clean_n", btn_clean_n,   3);
        check("midrst_pulses",  {press_pulse, release_pulse, long_press}, 0);
        run_cycles(3);
        check("in_rst_level", btn_level[0], 0);
        rst = 1'b0;
        clear_stats();
        start = cyc;
        run_cycles(25);
        check("post_rst_press_cnt",  press_cnt[0], 1);
        check("post_rst_press_edge", press_at[0],  start + 6);
        check("post_rst_long_cnt",   long_cnt[0],  1);
        check("post_rst_long_edge",  long_at[0],   start + 18);
        check("post_rst_no_release", rel_cnt[0],   0);
        btn_n[0] = 1'b1;
        run_cycles(10);

        check("press_release_overlap", overlap_cnt, 0);
        check("clean_n_complement",    clean_bad,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end conditioning stage for the stopwatch/timer push buttons, e.g. start_stop and hold.
- Takes raw, bouncing, active-low button inputs and produces clean outputs for the stopwatch control logic:
  - a synchronised, debounced level;
  - single-cycle press and release pulses;
  - a one-shot long-press pulse.
- One instance serves all buttons on the board; it sits between the pins and the stopwatch core.

Parameters:
NUM_BTN, 2, number of independent button channels
DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a new level (20 ms at 50 MHz); legal range 2 or more
LONG_PRESS_CYCLES, 50000000, cycles a debounced press must persist before long_press fires (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES
CNT_W, 26, counter width; must satisfy 2^CNT_W > LONG_PRESS_CYCLES

Ports:
CLK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
btn_n  input  NUM_BTN  raw button pins, active-low (0 = pressed), asynchronous to CLK_50
btn_level  output  NUM_BTN  debounced level, active-high (1 = pressed)
btn_clean_n  output  NUM_BTN  debounced level, active-low; equal to ~btn_level, for direct drive of active-low core inputs
press_pulse  output  NUM_BTN  one-cycle pulse when a press is accepted
release_pulse  output  NUM_BTN  one-cycle pulse when a release is accepted
long_press  output  NUM_BTN  one-cycle pulse, at most once per press

Behaviour:
- Channels are fully independent; every rule below applies per bit.
- Reset (async assert, sync release inside the design's reset network):
  - sync FFs = 1;
  - stable level = released;
  - debounce counter = 0; hold counter = 0; long_fired = 0;
  - outputs: btn_level = 0, btn_clean_n = 1, press_pulse = 0, release_pulse = 0, long_press = 0.
- Synchroniser: 2-FF chain on btn_n. The synced value s reflects the pin at the second clock edge after sampling.
- Debounce FSM: two states, RELEASED and PRESSED; the state holds the stable level.
  - Each clock: if s matches the current state, clear the debounce counter.
  - Otherwise increment it. When it would reach DEBOUNCE_CYCLES, switch state and clear the counter.
  - Result: a new level is accepted after exactly DEBOUNCE_CYCLES consecutive mismatching synced samples.
  - Any matching sample before then (a bounce) restarts the count from 0.
- Latency: a pin held low from clock edge k produces press_pulse = 1 and btn_level = 1 in the cycle after edge k+1+DEBOUNCE_CYCLES. Release has the same latency.
- press_pulse / release_pulse:
  - registered, high for exactly one cycle, coincident with the first cycle of the new btn_level value;
  - never both high on the same bit.
- Long press:
  - The hold counter clears on entry to PRESSED and increments every cycle while PRESSED, saturating.
  - When it reaches LONG_PRESS_CYCLES-1 and long_fired = 0, assert long_press for one cycle and set long_fired.
  - long_fired clears on entry to RELEASED.
  - A release accepted before the threshold produces no long_press.
- Counters never wrap.
- Reset asserted mid-debounce or mid-press: all state returns to reset values immediately. No pulse is emitted on reset entry or exit.
- A pin already held low when reset releases is treated as a fresh press: press_pulse fires after the normal latency.
- Glitch-free outputs: all outputs come straight from flops, with no combinational path from btn_n.

Test Plan:
(Bench overrides: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=12, NUM_BTN=2, 20 ns clock.)
- Reset check: hold reset 5 cycles with btn_n=2'b11 -> all outputs at reset values; release reset, idle 20 cycles -> no pulses.
- Clean press: drop btn_n[0] at edge 0 and hold -> press_pulse[0]=1 for exactly 1 cycle after edge 5; btn_level[0]=1 from the same cycle; btn_clean_n[0]=0; channel 1 untouched.
- Bounce rejection: btn_n[1] toggles 0,1,0,0,1,0,0,0,0,0… -> exactly one press_pulse[1], 4 accepted cycles after the final settle; no release_pulse during the bounce.
- Long press: hold btn_n[0] low 40 cycles -> one press_pulse and exactly one long_press pulse, 12 cycles after btn_level rises; then release -> one release_pulse, btn_level returns to 0 after 5 cycles.
- Short press: hold btn_n[0] low 10 cycles then high -> press_pulse and release_pulse each fire once; long_press never fires.
- Reset mid-operation: assert reset while btn_level[0]=1 and the hold counter = 6 -> outputs clear immediately with no pulse; with the pin still low after reset release -> press_pulse after 5 cycles and long_press 12 cycles later.
